tri_edge_setup: RTL
===================

// Module: tri_edge_setup
// PURPOSE
//  Parametrised two-stage triangle setup pipeline, ahead of the lambda/edge-walk stages.
//  Stage 1 registers per-edge deltas for all three edges, the vertex passthrough, and the
//  screen bounding box.
//  Stage 2 computes twice the signed area, applies a per-triangle cull mode and silently
//  drops culled triangles. A saturating cull counter records each drop.
//  Full valid/ready handshake on both sides, with bubble collapsing and no data loss under
//  backpressure.
// PARAMETERS
//  XWIDTH   9   signed screen X width
//  YWIDTH   8   signed screen Y width
//  ZWIDTH   16  depth width (opaque passthrough)
//  IDWIDTH  16  triangle ID width
//  CWIDTH   16  cull counter width
//  AWIDTH   (localparam) XWIDTH+YWIDTH+3, width of area2
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            reset, asynchronous, active-high
//  cull_mode  in   2            00 none; 01 cull area2==0; 10 cull area2<=0; 11 cull area2>=0
//  in_valid   in   1            input triangle valid
//  in_ready   out  1            input accepted when in_valid&&in_ready
//  tID_in     in   IDWIDTH      triangle ID
//  x1_in,x2_in,x3_in in XWIDTH each, signed; y1_in,y2_in,y3_in in YWIDTH each, signed
//  z1_in,z2_in,z3_in in ZWIDTH each
//  out_valid  out  1            output triangle valid
//  out_ready  in   1            downstream accepts when out_valid&&out_ready
//  tID_out    out  IDWIDTH      ID of output triangle
//  dlx_out    out  3*(YWIDTH+1) packed signed {e2,e1,e0}, edge e at [e*(YWIDTH+1)+:YWIDTH+1]
//  dly_out    out  3*(XWIDTH+1) packed signed {e2,e1,e0}
//  x_out/y_out/z_out out 3*XWIDTH/3*YWIDTH/3*ZWIDTH  packed {v3,v2,v1} passthrough
//  area2_out  out  AWIDTH       signed 2x triangle area
//  bbx_min,bbx_max out XWIDTH; bby_min,bby_max out YWIDTH  inclusive bounding box
//  cull_cnt   out  CWIDTH       culled-triangle count, saturating
// BEHAVIOUR
//  Reset:
//   - All outputs and internal stage-valid flags are 0.
//   - in_ready is 1 once reset is released.
//   - Reset asserted mid-operation discards all in-flight triangles immediately.
//  Edge math, vertices v1..v3, e=0..2, with n = (e+1) mod 3:
//   - dlx_e = y_n - y_e; dly_e = x_e - x_n. Sign-extend by one bit first; no overflow.
//  Area:
//   - area2 = (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1), full precision in AWIDTH.
//   - Computed in stage 2 from the stage-1 registers.
//  Bounding box: signed min/max of the three vertices, registered in stage 1.
//  cull_mode:
//   - Sampled with the triangle on input acceptance and carried in stage 1.
//   - Changing it affects only triangles accepted afterwards.
//  Pipeline and handshake:
//   - Stage s advances when !sN_valid || next stage accepts.
//   - s2 accepts when !out_valid || out_ready.
//   - in_ready = !s1_valid || s1_advance. This is a combinational path from out_ready.
//   - Latency is 2 cycles from input acceptance to out_valid when unstalled.
//   - Throughput is 1 triangle per cycle.
//  Stall:
//   - While out_valid && !out_ready, every output holds stable.
//   - Stage 1 holds once full. in_ready drops only when both stages hold data.
//  Cull:
//   - A triangle that meets its cull condition is not loaded into the output register.
//   - out_valid is not asserted for it, and the output register may take a bubble.
//   - cull_cnt increments by 1 in the cycle the triangle leaves stage 1.
//   - cull_cnt saturates at 2^CWIDTH-1.
//  Ordering: triangles leave in input order. Nothing is duplicated or lost.
//  Simultaneous accept and emit in one cycle is allowed. The pipeline stays full.
// TESTING
//  1. Reset: assert rst mid-stream with 2 triangles in flight.
//     -> out_valid=0 and cull_cnt=0 at once; in_ready=1 after release; no stale output.
//  2. Mode 00, v=(0,0),(10,0),(0,10), tID=5.
//     -> 2 cycles later: dlx={-10,10,0}, dly={0,10,-10}, area2=100, bbox x0..10 y0..10, tID=5.
//  3. Mode 10, v=(0,0),(0,10),(10,0).
//     -> area2=-100, triangle dropped, out_valid stays 0, cull_cnt=1.
//  4. Stream 6 triangles back-to-back; out_ready low for cycles 3..5.
//     -> in_ready low only while both stages are full; outputs stable while stalled;
//        IDs emerge in order with none lost.
//  5. Extremes x∈{-256,255}, y∈{-128,127}, v=(-256,-128),(255,-128),(-256,127).
//     -> dly0=-511, dlx1=255, area2=130305, no overflow.
//  6. Mode 01 with 3 collinear triangles; CWIDTH=2 with 5 culls.
//     -> all 3 collinear triangles are dropped; in the CWIDTH=2 run cull_cnt saturates at 3.

Source files
------------

// File: rtl/tri_edge_setup.sv
// Two-stage triangle setup: stage 1 registers edge deltas, vertices and bounding box;
// stage 2 forms twice the signed area, culls per triangle and drives the output register.
module tri_edge_setup #(
    parameter int XWIDTH  = 9,
    parameter int YWIDTH  = 8,
    parameter int ZWIDTH  = 16,
    parameter int IDWIDTH = 16,
    parameter int CWIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    cull_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IDWIDTH-1:0]            tID_in,
    input  logic [XWIDTH-1:0]             x1_in,
    input  logic [XWIDTH-1:0]             x2_in,
    input  logic [XWIDTH-1:0]             x3_in,
    input  logic [YWIDTH-1:0]             y1_in,
    input  logic [YWIDTH-1:0]             y2_in,
    input  logic [YWIDTH-1:0]             y3_in,
    input  logic [ZWIDTH-1:0]             z1_in,
    input  logic [ZWIDTH-1:0]             z2_in,
    input  logic [ZWIDTH-1:0]             z3_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDWIDTH-1:0]            tID_out,
    output logic [3*(YWIDTH+1)-1:0]       dlx_out,
    output logic [3*(XWIDTH+1)-1:0]       dly_out,
    output logic [3*XWIDTH-1:0]           x_out,
    output logic [3*YWIDTH-1:0]           y_out,
    output logic [3*ZWIDTH-1:0]           z_out,
    output logic [XWIDTH+YWIDTH+2:0]      area2_out,
    output logic [XWIDTH-1:0]             bbx_min,
    output logic [XWIDTH-1:0]             bbx_max,
    output logic [YWIDTH-1:0]             bby_min,
    output logic [YWIDTH-1:0]             bby_max,
    output logic [CWIDTH-1:0]             cull_cnt
);

    localparam int AWIDTH = XWIDTH + YWIDTH + 3;
    localparam int DXW    = XWIDTH + 1;
    localparam int DYW    = YWIDTH + 1;

    logic                   s1_valid_q;
    logic [IDWIDTH-1:0]     s1_tid_q;
    logic [1:0]             s1_mode_q;
    logic [3*XWIDTH-1:0]    s1_x_q;
    logic [3*YWIDTH-1:0]    s1_y_q;
    logic [3*ZWIDTH-1:0]    s1_z_q;
    logic [3*DYW-1:0]       s1_dlx_q;
    logic [3*DXW-1:0]       s1_dly_q;
    logic [XWIDTH-1:0]      s1_bxmin_q, s1_bxmax_q;
    logic [YWIDTH-1:0]      s1_bymin_q, s1_bymax_q;

    logic                   out_valid_q;
    logic [IDWIDTH-1:0]     tid_out_q;
    logic [3*DYW-1:0]       dlx_out_q;
    logic [3*DXW-1:0]       dly_out_q;
    logic [3*XWIDTH-1:0]    x_out_q;
    logic [3*YWIDTH-1:0]    y_out_q;
    logic [3*ZWIDTH-1:0]    z_out_q;
    logic [AWIDTH-1:0]      area_out_q;
    logic [XWIDTH-1:0]      bxmin_out_q, bxmax_out_q;
    logic [YWIDTH-1:0]      bymin_out_q, bymax_out_q;
    logic [CWIDTH-1:0]      cull_cnt_q, cull_cnt_d;

    logic                   s2_accept_s;
    logic                   s1_adv_s;
    logic                   keep_s;
    logic                   cull_s;

    logic [XWIDTH-1:0]      xv_s [3];
    logic [YWIDTH-1:0]      yv_s [3];
    logic [3*DYW-1:0]       dlx_d;
    logic [3*DXW-1:0]       dly_d;
    logic [XWIDTH-1:0]      bxmin_d, bxmax_d;
    logic [YWIDTH-1:0]      bymin_d, bymax_d;

    logic [DXW-1:0]         ax_s, bx_s;
    logic [DYW-1:0]         ay_s, by_s;
    logic signed [AWIDTH-1:0] axe_s, bxe_s, aye_s, bye_s, area_s;

    // in_ready is combinational from out_ready so a full pipe can accept while it emits
    assign s2_accept_s = !out_valid_q || out_ready;
    assign s1_adv_s    = !s1_valid_q || s2_accept_s;
    assign in_ready    = !rst && (!s1_valid_q || s1_adv_s);
    assign keep_s      = s1_valid_q && !cull_s;

    assign xv_s[0] = x1_in;
    assign xv_s[1] = x2_in;
    assign xv_s[2] = x3_in;
    assign yv_s[0] = y1_in;
    assign yv_s[1] = y2_in;
    assign yv_s[2] = y3_in;

    // Edge deltas are one bit wider than the coordinates, so they never overflow
    always_comb begin
        dlx_d   = '0;
        dly_d   = '0;
        bxmin_d = xv_s[0];
        bxmax_d = xv_s[0];
        bymin_d = yv_s[0];
        bymax_d = yv_s[0];
        for (int e = 0; e < 3; e++) begin
            dlx_d[e*DYW +: DYW] = {yv_s[(e+1)%3][YWIDTH-1], yv_s[(e+1)%3]}
                                - {yv_s[e][YWIDTH-1], yv_s[e]};
            dly_d[e*DXW +: DXW] = {xv_s[e][XWIDTH-1], xv_s[e]}
                                - {xv_s[(e+1)%3][XWIDTH-1], xv_s[(e+1)%3]};
        end
        for (int e = 1; e < 3; e++) begin
            bxmin_d = ($signed(xv_s[e]) < $signed(bxmin_d)) ? xv_s[e] : bxmin_d;
            bxmax_d = ($signed(xv_s[e]) > $signed(bxmax_d)) ? xv_s[e] : bxmax_d;
            bymin_d = ($signed(yv_s[e]) < $signed(bymin_d)) ? yv_s[e] : bymin_d;
            bymax_d = ($signed(yv_s[e]) > $signed(bymax_d)) ? yv_s[e] : bymax_d;
        end
    end

    // Stage 1 register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tid_q   <= '0;
            s1_mode_q  <= 2'b00;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_z_q     <= '0;
            s1_dlx_q   <= '0;
            s1_dly_q   <= '0;
            s1_bxmin_q <= '0;
            s1_bxmax_q <= '0;
            s1_bymin_q <= '0;
            s1_bymax_q <= '0;
        end else if (s1_adv_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_tid_q   <= tID_in;
                s1_mode_q  <= cull_mode;
                s1_x_q     <= {x3_in, x2_in, x1_in};
                s1_y_q     <= {y3_in, y2_in, y1_in};
                s1_z_q     <= {z3_in, z2_in, z1_in};
                s1_dlx_q   <= dlx_d;
                s1_dly_q   <= dly_d;
                s1_bxmin_q <= bxmin_d;
                s1_bxmax_q <= bxmax_d;
                s1_bymin_q <= bymin_d;
                s1_bymax_q <= bymax_d;
            end
        end
    end

    // area2 = (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1), operands sign-extended to AWIDTH
    assign ax_s  = {s1_x_q[2*XWIDTH-1], s1_x_q[XWIDTH +: XWIDTH]}   - {s1_x_q[XWIDTH-1], s1_x_q[0 +: XWIDTH]};
    assign bx_s  = {s1_x_q[3*XWIDTH-1], s1_x_q[2*XWIDTH +: XWIDTH]} - {s1_x_q[XWIDTH-1], s1_x_q[0 +: XWIDTH]};
    assign ay_s  = {s1_y_q[3*YWIDTH-1], s1_y_q[2*YWIDTH +: YWIDTH]} - {s1_y_q[YWIDTH-1], s1_y_q[0 +: YWIDTH]};
    assign by_s  = {s1_y_q[2*YWIDTH-1], s1_y_q[YWIDTH +: YWIDTH]}   - {s1_y_q[YWIDTH-1], s1_y_q[0 +: YWIDTH]};
    assign axe_s = $signed({{(AWIDTH-DXW){ax_s[DXW-1]}}, ax_s});
    assign bxe_s = $signed({{(AWIDTH-DXW){bx_s[DXW-1]}}, bx_s});
    assign aye_s = $signed({{(AWIDTH-DYW){ay_s[DYW-1]}}, ay_s});
    assign bye_s = $signed({{(AWIDTH-DYW){by_s[DYW-1]}}, by_s});
    assign area_s = axe_s * aye_s - bxe_s * bye_s;

    // Cull decision uses the mode captured with the triangle
    always_comb begin
        cull_s = 1'b0;
        case (s1_mode_q)
            2'b00:   cull_s = 1'b0;
            2'b01:   cull_s = (area_s == '0);
            2'b10:   cull_s = area_s[AWIDTH-1] || (area_s == '0);
            2'b11:   cull_s = !area_s[AWIDTH-1];
            default: cull_s = 1'b0;
        endcase
    end

    // Saturating count of triangles dropped as they leave stage 1
    always_comb begin
        cull_cnt_d = cull_cnt_q;
        if (s1_valid_q && s2_accept_s && cull_s && (cull_cnt_q != {CWIDTH{1'b1}})) begin
            cull_cnt_d = cull_cnt_q + {{(CWIDTH-1){1'b0}}, 1'b1};
        end else begin
            cull_cnt_d = cull_cnt_q;
        end
    end

    // Output register; a culled triangle leaves a bubble rather than a stale entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            tid_out_q   <= '0;
            dlx_out_q   <= '0;
            dly_out_q   <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            area_out_q  <= '0;
            bxmin_out_q <= '0;
            bxmax_out_q <= '0;
            bymin_out_q <= '0;
            bymax_out_q <= '0;
            cull_cnt_q  <= '0;
        end else begin
            cull_cnt_q <= cull_cnt_d;
            if (s2_accept_s) begin
                out_valid_q <= keep_s;
                if (keep_s) begin
                    tid_out_q   <= s1_tid_q;
                    dlx_out_q   <= s1_dlx_q;
                    dly_out_q   <= s1_dly_q;
                    x_out_q     <= s1_x_q;
                    y_out_q     <= s1_y_q;
                    z_out_q     <= s1_z_q;
                    area_out_q  <= area_s;
                    bxmin_out_q <= s1_bxmin_q;
                    bxmax_out_q <= s1_bxmax_q;
                    bymin_out_q <= s1_bymin_q;
                    bymax_out_q <= s1_bymax_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign tID_out   = tid_out_q;
    assign dlx_out   = dlx_out_q;
    assign dly_out   = dly_out_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
    assign area2_out = area_out_q;
    assign bbx_min   = bxmin_out_q;
    assign bbx_max   = bxmax_out_q;
    assign bby_min   = bymin_out_q;
    assign bby_max   = bymax_out_q;
    assign cull_cnt  = cull_cnt_q;

endmodule
